// File: rtl/fir_block_scheduler.sv
// Block sequencer for a 3-lane parallel FIR: packs a serial stream into 3-sample blocks,
// tracks them through the fixed filter latency, buffers the results and re-serialises them.
module fir_block_scheduler #(
  parameter int DATA_W      = 32,
  parameter int OUT_W       = 64,
  parameter int LATENCY     = 102,
  parameter int OBUF_BLOCKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  input  logic                     flush,
  output logic signed [DATA_W-1:0] f_x0,
  output logic signed [DATA_W-1:0] f_x1,
  output logic signed [DATA_W-1:0] f_x2,
  input  logic signed [OUT_W-1:0]  f_y0,
  input  logic signed [OUT_W-1:0]  f_y1,
  input  logic signed [OUT_W-1:0]  f_y2,
  output logic                     m_valid,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy
);

  localparam int CW = $clog2(OBUF_BLOCKS + 2);
  localparam int AW = (OBUF_BLOCKS > 1) ? $clog2(OBUF_BLOCKS) : 1;
  localparam int EW = 3 * OUT_W + 2;

  typedef enum logic {ST_COLLECT, ST_FLUSH} state_t;

  state_t                     r_state, w_state_nxt;
  logic [1:0]                 r_cnt, w_cnt_nxt;
  logic signed [DATA_W-1:0]   r_lane0, r_lane1;
  logic                       r_run;
  logic                       w_credit_ok, w_accept, w_issue, w_issue_flush;

  logic                       r_vld_p0;
  logic [1:0]                 r_rc_p0;
  logic [LATENCY-1:0]         r_vsr;
  logic [1:0]                 r_rcsr [LATENCY];

  logic [CW-1:0]              w_in_flight, r_fcnt;
  logic [CW:0]                w_occ;
  logic [EW-1:0]              r_mem [OBUF_BLOCKS];
  logic [AW-1:0]              r_wptr, r_rptr;
  logic [1:0]                 r_sel;
  logic                       w_push, w_pop, w_hs, w_blk_end;
  logic [EW-1:0]              w_head;
  logic [1:0]                 w_head_rc;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(OBUF_BLOCKS - 1)) return '0;
    return p + AW'(1);
  endfunction

  // The block being presented this cycle counts as in flight alongside the tracking bits.
  always_comb begin
    w_in_flight = CW'(r_vld_p0);
    for (int i = 0; i < LATENCY; i++) w_in_flight = w_in_flight + CW'(r_vsr[i]);
  end

  assign w_occ       = {1'b0, w_in_flight} + {1'b0, r_fcnt};
  assign w_credit_ok = (w_occ < (CW+1)'(OBUF_BLOCKS));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    s_ready       = 1'b0;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_issue_flush = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        s_ready  = r_run & w_credit_ok;
        w_accept = s_valid & s_ready;
        if (w_accept) begin
          if (r_cnt == 2'd2) begin
            w_issue   = 1'b1;
            w_cnt_nxt = 2'd0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end else if (flush && (r_cnt != 2'd0)) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_credit_ok) begin
          w_issue       = 1'b1;
          w_issue_flush = 1'b1;
          w_cnt_nxt     = 2'd0;
          w_state_nxt   = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_COLLECT;
      r_cnt   <= 2'd0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= 1'b1;
    end
  end

  // Stage p0: lanes presented to the filter for exactly one cycle per block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_x0     <= '0;
      f_x1     <= '0;
      f_x2     <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_issue;
      if (w_issue) begin
        f_x0 <= r_lane0;
        f_x1 <= (w_issue_flush && (r_cnt < 2'd2)) ? '0 : r_lane1;
        f_x2 <= w_issue_flush ? '0 : s_data;
      end else begin
        f_x0 <= '0;
        f_x1 <= '0;
        f_x2 <= '0;
      end
    end
  end

  // Latency tracking: the tail bit lines up with valid results on f_y*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= r_vld_p0;
      for (int i = 1; i < LATENCY; i++) r_vsr[i] <= r_vsr[i-1];
    end
  end

  assign w_push = r_vsr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (w_accept && (r_cnt == 2'd0)) r_lane0 <= s_data;
    if (w_accept && (r_cnt == 2'd1)) r_lane1 <= s_data;
    r_rc_p0   <= w_issue_flush ? r_cnt : 2'd3;
    r_rcsr[0] <= r_rc_p0;
    for (int i = 1; i < LATENCY; i++) r_rcsr[i] <= r_rcsr[i-1];
    if (w_push) r_mem[r_wptr] <= {r_rcsr[LATENCY-1], f_y2, f_y1, f_y0};
  end

  // Output stage: head block is walked lane by lane and popped after its last real sample.
  assign w_head    = r_mem[r_rptr];
  assign w_head_rc = w_head[EW-1 -: 2];
  assign m_valid   = (r_fcnt != '0);
  assign w_hs      = m_valid & m_ready;
  assign w_blk_end = (r_sel == (w_head_rc - 2'd1));
  assign w_pop     = w_hs & w_blk_end;
  assign m_last    = m_valid & (w_head_rc != 2'd3) & w_blk_end;

  always_comb begin
    m_data = '0;
    if (m_valid) begin
      case (r_sel)
        2'd0:    m_data = $signed(w_head[OUT_W-1:0]);
        2'd1:    m_data = $signed(w_head[2*OUT_W-1:OUT_W]);
        default: m_data = $signed(w_head[3*OUT_W-1:2*OUT_W]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_sel  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_pop)      r_sel <= 2'd0;
      else if (w_hs)  r_sel <= r_sel + 2'd1;
    end
  end

  assign busy = (r_cnt != 2'd0) | (r_state == ST_FLUSH) | (w_in_flight != '0) | (r_fcnt != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_push |-> (r_fcnt < CW'(OBUF_BLOCKS)));

endmodule

// File: tb/tb_fir_block_scheduler.sv
// Scoreboard bench for fir_block_scheduler with a pure-delay stub filter (y = sign-extended x).
module tb_fir_block_scheduler;
  localparam int DATA_W      = 16;
  localparam int OUT_W       = 32;
  localparam int LATENCY     = 4;
  localparam int OBUF_BLOCKS = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     flush;
  logic signed [DATA_W-1:0] f_x0, f_x1, f_x2;
  logic signed [OUT_W-1:0]  f_y0, f_y1, f_y2;
  logic                     m_valid;
  logic signed [OUT_W-1:0]  m_data;
  logic                     m_last;
  logic                     m_ready;
  logic                     busy;

  int n_chk  = 0;
  int n_fail = 0;

  longint q_d[$];
  bit     q_l[$];
  longint q_x0[$], q_x1[$], q_x2[$];

  always #5 clk = ~clk;

  fir_block_scheduler #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .LATENCY(LATENCY), .OBUF_BLOCKS(OBUF_BLOCKS)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush),
    .f_x0(f_x0), .f_x1(f_x1), .f_x2(f_x2),
    .f_y0(f_y0), .f_y1(f_y1), .f_y2(f_y2),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy)
  );

  // Stub filter: LATENCY register stages, sign-extending each lane.
  logic signed [OUT_W-1:0] p0 [LATENCY];
  logic signed [OUT_W-1:0] p1 [LATENCY];
  logic signed [OUT_W-1:0] p2 [LATENCY];
  always @(posedge clk) begin
    p0[0] <= OUT_W'(f_x0);
    p1[0] <= OUT_W'(f_x1);
    p2[0] <= OUT_W'(f_x2);
    for (int i = 1; i < LATENCY; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
    end
  end
  assign f_y0 = p0[LATENCY-1];
  assign f_y1 = p1[LATENCY-1];
  assign f_y2 = p2[LATENCY-1];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input longint act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d, expected no event", name, act);
  endtask

  task automatic exp_blk(input longint a, input longint b, input longint c, input int rc);
    q_x0.push_back(a);
    q_x1.push_back(rc >= 2 ? b : 0);
    q_x2.push_back(rc == 3 ? c : 0);
    q_d.push_back(a); q_l.push_back(rc == 1);
    if (rc >= 2) begin q_d.push_back(b); q_l.push_back(rc == 2); end
    if (rc == 3) begin q_d.push_back(c); q_l.push_back(1'b0); end
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = DATA_W'(v);
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail("send_timeout", v);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q_d.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_pending_outputs", q_d.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_outputs();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_f_x0", f_x0, 0);
    chk("rst_f_x1", f_x1, 0);
    chk("rst_f_x2", f_x2, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
  endtask

  // Monitor: compares every output handshake and every lane presentation against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) begin
        if (q_d.size() == 0) fail("m_unexpected", m_data);
        else begin
          chk("m_data", m_data, q_d.pop_front());
          chk("m_last", m_last, q_l.pop_front());
        end
      end
      if (f_x0 != 0 || f_x1 != 0 || f_x2 != 0) begin
        if (q_x0.size() == 0) fail("f_x_unexpected", f_x0);
        else begin
          chk("f_x0", f_x0, q_x0.pop_front());
          chk("f_x1", f_x1, q_x1.pop_front());
          chk("f_x2", f_x2, q_x2.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs;
    rst = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b1;
    #3;
    chk_rst_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full block with latency check
    exp_blk(5, -7, 9, 3);
    send(5); send(-7); send(9);
    n = 0;
    @(negedge clk);
    while (f_x0 != 5 && n < 10) begin @(negedge clk); n++; end
    chk("full_fx_seen", f_x0, 5);
    @(negedge clk);
    chk("full_fx_one_cycle", f_x0, 0);
    repeat (3) @(negedge clk);
    chk("full_early_m_valid", m_valid, 0);
    @(negedge clk);
    chk("full_lat_m_valid", m_valid, 1);
    chk("full_lat_m_data", m_data, 5);
    wait_idle();

    // Flush of a 2-sample partial block
    exp_blk(11, 12, 0, 2);
    send(11); send(12);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle();

    // Flush with empty block is ignored
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_busy", busy, 0);
    chk("flush_empty_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // Flush coincident with an accept is ignored
    send(21);
    s_valid = 1'b1; s_data = DATA_W'(22); flush = 1'b1;
    @(negedge clk);
    chk("coinc_s_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("coinc_stays_collect", s_ready, 1);
    repeat (4) @(negedge clk);
    chk("coinc_busy_partial", busy, 1);
    @(posedge clk); #1;
    exp_blk(21, 22, 23, 3);
    send(23);
    wait_idle();

    // Backpressure and credits
    m_ready = 1'b0;
    exp_blk(31, 32, 33, 3); exp_blk(34, 35, 36, 3); exp_blk(37, 38, 39, 3);
    for (int v = 31; v <= 36; v++) send(v);
    s_valid = 1'b1; s_data = DATA_W'(37);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_ready) highs++;
    end
    chk("bp_s_ready_low_cycles", highs, 0);
    chk("bp_m_valid", m_valid, 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(37); send(38); send(39);
    wait_idle();

    // Drain stall with concurrent capture
    m_ready = 1'b0;
    exp_blk(41, 42, 43, 3); exp_blk(44, 45, 46, 3);
    send(41); send(42); send(43);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_m_valid_start", m_valid, 1);
    @(posedge clk); #1;
    send(44); send(45); send(46);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_data", m_data, 41);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle();

    // Reset mid-stream discards everything
    exp_blk(51, 52, 53, 3);
    send(51); send(52); send(53); send(54);
    #2;
    rst = 1'b0;
    #1;
    chk_rst_outputs();
    q_d.delete(); q_l.delete(); q_x0.delete(); q_x1.delete(); q_x2.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_m_valid", m_valid, 0);
    @(posedge clk); #1;
    exp_blk(61, -62, 63, 3);
    send(61); send(-62); send(63);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
